// File: rtl/xor3_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor3_chk_pkg
// Description : Shared types and constants for the XOR3 response checker.
//               Holds the run-state encoding, the saturation / "no error"
//               sentinels and the default MISR polynomial and seed.
// Revision    : 1.0 - initial release
// ============================================================================
package xor3_chk_pkg;

    // Run-state encoding (explicit 2-bit width)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_t;

    // Width of the sample counters, error counter and first-error index
    localparam int          CNT_W      = 16;

    // Error counter saturates here instead of wrapping
    localparam logic [15:0] ERR_SAT    = 16'hFFFF;

    // FIRST_ERR value meaning "no failing sample seen yet"
    localparam logic [15:0] FIRST_NONE = 16'hFFFF;

    // Default MISR feedback polynomial and reload value
    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_SEED   = 16'hFFFF;

endpackage : xor3_chk_pkg
`default_nettype wire

// File: rtl/misr_reg.sv
`default_nettype none
// ============================================================================
// Module      : misr_reg
// Description : Multiple-input signature register. Each enabled cycle the
//               register shifts left by one, folds the feedback polynomial
//               in when the outgoing MSB is set, and XORs in the parallel
//               data word.
// Ports       : CLK  - clock, rising edge
//               RST  - synchronous active-high reset (loads SEED)
//               load - reload SEED (takes priority over en)
//               en   - compact din into the signature this cycle
//               din  - parallel data word, SIG_W bits
//               sig  - current signature
// Revision    : 1.0 - initial release
// ============================================================================
module misr_reg
    import xor3_chk_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_fb;
    logic [SIG_W-1:0] w_next;

    // Feedback applies when the bit shifted out of the top is a one
    assign w_fb   = r_sig[SIG_W-1] ? POLY : '0;
    assign w_next = {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ din;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sig <= SEED;
        end else if (load) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule : misr_reg
`default_nettype wire

// File: rtl/xor3_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : xor3_response_checker
// Description : Observation stage for a bank of WIDTH three-input XOR cells.
//               Each accepted sample compares Q against IN1^IN2^IN3, counts
//               mismatching samples (saturating), records the index of the
//               first failing sample and compacts Q into a MISR signature.
//               After LEN samples the block reports DONE and PASS.
// Ports       : CLK       - clock, rising edge
//               RST       - synchronous active-high reset
//               START     - begin a run (honoured in IDLE / DONE only)
//               LEN       - samples in the run, latched on START
//               VALID     - IN1/IN2/IN3/Q carry a sample this cycle
//               IN1..IN3  - operands driven into the cells
//               Q         - cell outputs under test
//               BUSY      - run in progress
//               DONE      - run finished, results stable
//               SIG       - MISR signature of all accepted Q vectors
//               ERR_CNT   - mismatching samples, saturating at 16'hFFFF
//               FIRST_ERR - index of first mismatch, 16'hFFFF if none
//               PASS      - DONE with no mismatches
// Revision    : 1.0 - initial release
// ============================================================================
module xor3_response_checker
    import xor3_chk_pkg::*;
#(
    parameter int               WIDTH = 8,      // 1..SIG_W
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [15:0]      LEN,
    input  logic             VALID,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [WIDTH-1:0] IN3,
    input  logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic [SIG_W-1:0] SIG,
    output logic [15:0]      ERR_CNT,
    output logic [15:0]      FIRST_ERR,
    output logic             PASS
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    chk_state_t        r_state;
    chk_state_t        w_next_state;

    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_first_err;

    // ------------------------------------------------------------------
    // Qualifiers
    // ------------------------------------------------------------------
    logic              w_start_ok;
    logic              w_accept;
    logic              w_last;
    logic [WIDTH-1:0]  w_golden;
    logic              w_mismatch;
    logic [SIG_W-1:0]  w_din;

    // START only counts when no run is in progress
    assign w_start_ok = START && (r_state != ST_RUN);
    assign w_accept   = VALID && (r_state == ST_RUN);

    // r_len is never zero while in RUN, so len-1 cannot underflow here
    assign w_last     = w_accept && (r_idx == (r_len - 16'd1));

    assign w_golden   = IN1 ^ IN2 ^ IN3;

    // One event per sample regardless of how many bits differ. An X that
    // leaves the compare unresolved is treated as "no mismatch" by the
    // if-statements below.
    assign w_mismatch = (Q != w_golden);

    // ------------------------------------------------------------------
    // Zero-extend Q to the signature width
    // ------------------------------------------------------------------
    generate
        if (WIDTH < SIG_W) begin : g_pad
            assign w_din = {{(SIG_W-WIDTH){1'b0}}, Q};
        end else begin : g_nopad
            assign w_din = Q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    // An empty run skips straight to DONE
                    w_next_state = (LEN != 16'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        PASS = 1'b0;
        case (r_state)
            ST_RUN: begin
                BUSY = 1'b1;
            end
            ST_DONE: begin
                DONE = 1'b1;
                PASS = (r_err_cnt == 16'd0);
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Run length, sample index, error counter and first-error index
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_len       <= 16'd0;
            r_idx       <= 16'd0;
            r_err_cnt   <= 16'd0;
            r_first_err <= FIRST_NONE;
        end else if (w_start_ok) begin
            r_len       <= LEN;
            r_idx       <= 16'd0;
            r_err_cnt   <= 16'd0;
            r_first_err <= FIRST_NONE;
        end else if (w_accept) begin
            r_idx <= r_idx + 16'd1;
            if (w_mismatch) begin
                if (r_err_cnt != ERR_SAT) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                // Only the first failing sample is recorded
                if (r_first_err == FIRST_NONE) begin
                    r_first_err <= r_idx;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Signature compactor. load and en are mutually exclusive because a
    // start is only honoured outside RUN and acceptance only inside it.
    // ------------------------------------------------------------------
    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .CLK   (CLK),
        .RST   (RST),
        .load  (w_start_ok),
        .en    (w_accept),
        .din   (w_din),
        .sig   (SIG)
    );

    assign ERR_CNT   = r_err_cnt;
    assign FIRST_ERR = r_first_err;

endmodule : xor3_response_checker
`default_nettype wire

// File: tb/tb_xor3_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor3_response_checker
// Description : Self-checking bench for xor3_response_checker. A run-level
//               reference model computes the expected results of each run
//               and pushes them into a queue; a monitor pops and compares
//               whenever the DUT presents a freshly completed run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor3_response_checker;

    localparam int          WIDTH = 8;
    localparam int          SIG_W = 16;
    localparam logic [15:0] M_POLY = 16'h1021;
    localparam logic [15:0] M_SEED = 16'hFFFF;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic [15:0]      LEN;
    logic             VALID;
    logic [WIDTH-1:0] IN1, IN2, IN3, Q;
    logic             BUSY, DONE, PASS;
    logic [SIG_W-1:0] SIG;
    logic [15:0]      ERR_CNT, FIRST_ERR;

    xor3_response_checker #(
        .WIDTH (WIDTH),
        .SIG_W (SIG_W),
        .POLY  (M_POLY),
        .SEED  (M_SEED)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .LEN       (LEN),
        .VALID     (VALID),
        .IN1       (IN1),
        .IN2       (IN2),
        .IN3       (IN3),
        .Q         (Q),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .SIG       (SIG),
        .ERR_CNT   (ERR_CNT),
        .FIRST_ERR (FIRST_ERR),
        .PASS      (PASS)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] sig;
        logic [15:0] err;
        logic [15:0] first;
        logic        pass;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Run-level reference model
    bit          m_running;
    logic [15:0] m_len, m_idx, m_sig, m_err, m_first;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Signature as polynomial arithmetic: multiply by x modulo POLY, add Q
    function automatic logic [15:0] sig_after(input logic [15:0] s, input logic [7:0] q);
        logic [16:0] p;
        p = {s, 1'b0};
        if (p[16]) p = p ^ {1'b1, M_POLY};
        return p[15:0] ^ {8'h00, q};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        m_running = 1'b0;
        m_len     = 16'd0;
        m_idx     = 16'd0;
        m_sig     = M_SEED;
        m_err     = 16'd0;
        m_first   = 16'hFFFF;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1; START = 1'b0; VALID = 1'b0;
        repeat (n) step();
        model_clear();
        exp_q.delete();
        @(negedge CLK);
        check1 ("rst_busy",  BUSY, 1'b0);
        check1 ("rst_done",  DONE, 1'b0);
        check1 ("rst_pass",  PASS, 1'b0);
        check16("rst_sig",   SIG, 16'hFFFF);
        check16("rst_err",   ERR_CNT, 16'd0);
        check16("rst_first", FIRST_ERR, 16'hFFFF);
        RST = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] len);
        START = 1'b1;
        LEN   = len;
        step();
        START = 1'b0;
        if (!m_running) begin
            m_len = len; m_idx = 16'd0; m_sig = M_SEED;
            m_err = 16'd0; m_first = 16'hFFFF;
            if (len == 16'd0) begin
                exp_q.push_back('{sig: M_SEED, err: 16'd0, first: 16'hFFFF, pass: 1'b1});
                @(negedge CLK);
                check1("len0_done", DONE, 1'b1);
                check1("len0_busy", BUSY, 1'b0);
            end else begin
                m_running = 1'b1;
            end
        end
    endtask

    // One sample on the bus for one cycle, then 'gap' idle cycles.
    // A stray START may ride along; it must be ignored since a run is active.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] q, input int gap, input bit stray);
        IN1 = a; IN2 = b; IN3 = c; Q = q; VALID = 1'b1;
        if (stray) begin
            START = 1'b1;
            LEN   = 16'($urandom_range(0, 5));
        end
        step();
        VALID = 1'b0;
        START = 1'b0;
        if (m_running) begin
            m_sig = sig_after(m_sig, q);
            if (q != (a ^ b ^ c)) begin
                if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                if (m_first == 16'hFFFF) m_first = m_idx;
            end
            m_idx = m_idx + 16'd1;
            if (m_idx == m_len) begin
                m_running = 1'b0;
                exp_q.push_back('{sig: m_sig, err: m_err, first: m_first,
                                  pass: (m_err == 16'd0)});
                @(negedge CLK);
                check1("last_done", DONE, 1'b1);
                check1("last_busy", BUSY, 1'b0);
            end
        end
        repeat (gap) step();
    endtask

    task automatic send_rand(input int gap, input bit stray);
        logic [7:0] a, b, c, q;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        q = a ^ b ^ c;
        if ($urandom_range(0, 3) == 0) q = q ^ (8'h01 << $urandom_range(0, 7));
        send(a, b, c, q, gap, stray);
    endtask

    // ------------------------------------------------------------------
    // Monitor: a result is presented when DONE rises, or when DONE stays
    // high across a START that restarted an empty run.
    // ------------------------------------------------------------------
    logic prev_done     = 1'b0;
    logic start_pending = 1'b0;

    always @(negedge CLK) begin
        exp_t e;
        if (DONE === 1'b1 && (!prev_done || start_pending)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=DONE required=no_result_pending");
            end else begin
                e = exp_q.pop_front();
                check16("sb_sig",   SIG, e.sig);
                check16("sb_err",   ERR_CNT, e.err);
                check16("sb_first", FIRST_ERR, e.first);
                check1 ("sb_pass",  PASS, e.pass);
                check1 ("sb_busy",  BUSY, 1'b0);
            end
        end
        prev_done     = (DONE === 1'b1);
        start_pending = (START === 1'b1) && (BUSY === 1'b0) && (RST === 1'b0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        RST = 1'b1; START = 1'b0; LEN = 16'd0; VALID = 1'b0;
        IN1 = '0; IN2 = '0; IN3 = '0; Q = '0;
        model_clear();

        // Reset then idle
        do_reset(2);
        repeat (2) step();

        // Single all-zero sample
        start_run(16'd1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check16("single_sig",  SIG, 16'hEFDF);
        check1 ("single_pass", PASS, 1'b1);

        // Zero length from IDLE
        do_reset(1);
        start_run(16'd0);
        check16("len0_sig", SIG, 16'hFFFF);
        check1 ("len0_pass", PASS, 1'b1);
        step();

        // Injected fault on sample 2, VALID every other cycle
        start_run(16'd4);
        send(8'hA5, 8'h0F, 8'hF0, 8'h5A, 1, 1'b0);
        send(8'hA5, 8'h0F, 8'hF0, 8'h5A, 1, 1'b0);
        send(8'hA5, 8'hF0 ^ 8'hF0 ^ 8'h0F, 8'hF0, 8'h5B, 1, 1'b0);
        send(8'hA5, 8'h0F, 8'hF0, 8'h5A, 0, 1'b0);
        check16("fault_err",   ERR_CNT, 16'd1);
        check16("fault_first", FIRST_ERR, 16'd2);
        check1 ("fault_pass",  PASS, 1'b0);
        step();

        // START while busy is ignored; START from DONE restarts cleanly
        start_run(16'd4);
        send_rand(0, 1'b0);
        start_run(16'd2);
        send_rand(1, 1'b0);
        send_rand(0, 1'b0);
        send_rand(0, 1'b0);
        start_run(16'd3);
        @(negedge CLK);
        check1 ("restart_busy",  BUSY, 1'b1);
        check1 ("restart_done",  DONE, 1'b0);
        check16("restart_err",   ERR_CNT, 16'd0);
        check16("restart_first", FIRST_ERR, 16'hFFFF);
        check16("restart_sig",   SIG, 16'hFFFF);
        repeat (3) send_rand(0, 1'b0);
        step();

        // Reset in the middle of a run
        start_run(16'd4);
        send_rand(0, 1'b0);
        send_rand(0, 1'b0);
        do_reset(1);
        start_run(16'd1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check16("post_rst_sig", SIG, 16'hEFDF);
        step();

        // Randomized runs, including empty runs restarted from DONE,
        // stray STARTs during a run and VALID outside a run
        for (int r = 0; r < 24; r++) begin
            start_run(16'($urandom_range(0, 10)));
            while (m_running) begin
                send_rand($urandom_range(0, 2), ($urandom_range(0, 5) == 0));
            end
            IN1 = 8'($urandom); IN2 = 8'($urandom); IN3 = 8'($urandom);
            Q = 8'($urandom); VALID = 1'b1;
            step();
            VALID = 1'b0;
            @(negedge CLK);
            check16("idle_valid_sig", SIG, m_sig);
            check16("idle_valid_err", ERR_CNT, m_err);
        end

        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_results actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_xor3_response_checker
`default_nettype wire

// File: doc/xor3_response_checker.md
Name: xor3_response_checker

Overview:
- Downstream observation stage for a bank of WIDTH three-input XOR standard cells under power/functional test.
- Each accepted sample carries the three operand vectors driven into the cells and the cells' Q outputs.
- The block checks Q against the golden IN1^IN2^IN3, counts mismatching samples and records the first failing index.
- It compacts all Q vectors into a MISR signature and reports PASS/DONE after a programmed sample count.

Parameters:
- WIDTH, 8, number of XOR3 cells observed in parallel (1..SIG_W).
- SIG_W, 16, MISR signature width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- SEED, 16'hFFFF, MISR initial value loaded on START.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous active-high reset.
- START  input  1  begin a run; sampled in IDLE or DONE only.
- LEN  input  16  number of samples in the run; latched on START.
- VALID  input  1  IN1/IN2/IN3/Q hold a sample this cycle.
- IN1  input  WIDTH  operand 1 per cell.
- IN2  input  WIDTH  operand 2 per cell.
- IN3  input  WIDTH  operand 3 per cell.
- Q  input  WIDTH  cell outputs under test.
- BUSY  output  1  high in RUN.
- DONE  output  1  high in DONE; results valid.
- SIG  output  SIG_W  MISR signature.
- ERR_CNT  output  16  count of mismatching samples, saturating.
- FIRST_ERR  output  16  index of first mismatching sample; 16'hFFFF if none.
- PASS  output  1  DONE && ERR_CNT==0.

Behaviour:
- Reset: synchronous active-high on CLK, with RST held high on the rising edge. It applies in any state, including mid-run. State goes to IDLE.
- Reset values: BUSY=0, DONE=0, PASS=0, SIG=SEED, ERR_CNT=0, FIRST_ERR=16'hFFFF, sample index=0, latched LEN=0.
- States:
  - IDLE -> RUN on START when LEN!=0.
  - IDLE -> DONE on START when LEN==0.
  - RUN -> DONE on acceptance of the sample with index latched_LEN-1.
  - DONE -> RUN or DONE on a new START, using the same LEN rule.
  - DONE holds all results until then.
- START handling:
  - At cycle t, in IDLE or DONE: SIG:=SEED, ERR_CNT:=0, FIRST_ERR:=16'hFFFF, index:=0, LEN latched. New state is visible at t+1.
  - START in RUN is ignored.
  - VALID outside RUN is ignored.
- Sample acceptance: state==RUN && VALID. VALID may be deasserted for any number of cycles; the run simply stalls.
- Per accepted sample:
  - Mismatch = (Q != (IN1^IN2^IN3)), evaluated over all WIDTH bits; one event per sample, not per bit.
  - ERR_CNT increments on mismatch and saturates at 16'hFFFF.
  - FIRST_ERR is written with the current index only while it still equals 16'hFFFF.
  - Index increments by 1.
- MISR update per accepted sample:
  - SIG_next = ({SIG[SIG_W-2:0],1'b0} ^ (SIG[SIG_W-1] ? POLY : 0)) ^ zero-extended Q.
  - SIG is unchanged on non-accepted cycles.
- Latency: the last sample is accepted at cycle t. At t+1: BUSY=0, DONE=1, and SIG/ERR_CNT/FIRST_ERR already include that sample. PASS is valid in the same cycle.
- LEN==0: RUN is skipped. DONE=1 one cycle after START, with SIG=SEED and PASS=1.
- Simultaneous RST and START: RST wins.
- X on Q is not filtered; X propagates to SIG and counts as a mismatch only if the compare resolves.

Decomposition:
- Shared package xor3_chk_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - ERR_SAT = 16'hFFFF;
  - FIRST_NONE = 16'hFFFF;
  - default POLY/SEED constants.
- One sub-module, misr_reg (parameters SIG_W, POLY, SEED; ports CLK, RST, load, en, din, sig), instantiated once.
- Compare, counters and FSM stay in the top.

Test Plan:
- Reset then idle: RST=1 for 2 cycles -> BUSY=0, DONE=0, SIG=16'hFFFF, ERR_CNT=0, FIRST_ERR=16'hFFFF.
- Single sample: START, LEN=1, then VALID with IN1=IN2=IN3=8'h00, Q=8'h00 -> next cycle DONE=1, SIG=16'hEFDF, ERR_CNT=0, PASS=1.
- Zero length: START with LEN=0 -> DONE=1 next cycle, SIG=16'hFFFF, PASS=1, BUSY never asserted.
- Injected fault with gaps:
  - Stimulus: LEN=4; VALID high every other cycle; IN1=8'hA5, IN2=8'h0F, IN3=8'hF0; Q=8'h5A on samples 0, 1, 3 and Q=8'h5B on sample 2.
  - Response: ERR_CNT=1, FIRST_ERR=2, PASS=0, DONE asserted the cycle after the 4th accepted sample.
- START ignored while busy: second START with LEN=2 during a LEN=4 run -> run still completes after 4 samples. Then START from DONE -> counters clear and a new run begins.
- Reset mid-run: RST after 2 of 4 samples -> IDLE with reset values. A following LEN=1 run with Q=8'h00 yields SIG=16'hEFDF.
